// File: rtl/bus_responder_6502_if.sv
// Purpose : CPU-side bus bundle for bus_responder_6502 (address, strobes, RDY, opcode count).
// Ports   : master = CPU/testbench side, slave = responder side.
// Note    : the tristate data bus is a direct inout on the responder, not a member here.
interface bus_responder_6502_if;
  logic [15:0] address;
  logic        readNotWrite;
  logic        sync;
  logic        ready;
  logic [15:0] opcodeCount;

  modport master (output address, readNotWrite, sync, input  ready, opcodeCount);
  modport slave  (input  address, readNotWrite, sync, output ready, opcodeCount);
endinterface

// File: rtl/bus_responder_6502.sv
// Purpose : memory-side responder for the 6502 bus: mirrored RAM, vectors, open bus.
// Latency : reads valid after the sampling edge plus WAIT_STATES stall cycles; writes take one edge.
// Backpr. : reads stall the CPU through ready=0 during WAIT; writes are never stalled.
// Ports   : clock0, reset (async active-low), bus (slave modport: address, readNotWrite,
//           sync, ready, opcodeCount), data (shared tristate byte bus).
// Option  : define BUS_RESPONDER_OPCODE_COUNT_EN to build the opcode fetch counter.
module bus_responder_6502 #(
  parameter int          RAM_ADDR_BITS = 11,
  parameter logic [15:0] RESET_VECTOR  = 16'h8000,
  parameter int          WAIT_STATES   = 0
) (
  input  logic                 clock0,
  input  logic                 reset,
  bus_responder_6502_if.slave  bus,
  inout  wire  [7:0]           data
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_count, wait_nxt;
  logic [15:0] addr_hold, hold_nxt;
  logic [7:0]  read_data;
  logic [7:0]  open_bus;
  logic        rd_load;
  logic        wr_en;
  logic [15:0] sel_addr;
  logic [7:0]  dec_byte;

  logic [7:0] mem [2**RAM_ADDR_BITS];

  // Once a stalled read is accepted the decode follows the held address,
  // so the CPU may wander the address bus during WAIT without effect.
  assign sel_addr = (state == IDLE) ? bus.address : addr_hold;

  always_comb begin
    dec_byte = open_bus;
    if (sel_addr < 16'h2000) begin
      dec_byte = mem[sel_addr[RAM_ADDR_BITS-1:0]];
    end else if (sel_addr >= 16'hFFFA) begin
      dec_byte = sel_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_count;
    hold_nxt  = addr_hold;
    rd_load   = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.readNotWrite) begin
          if (WAIT_STATES == 0) begin
            rd_load = 1'b1;
          end else begin
            wait_nxt  = 4'(WAIT_STATES - 1);
            hold_nxt  = bus.address;
            state_nxt = WAIT;
          end
        end else begin
          wr_en = 1'b1;
        end
      end
      WAIT: begin
        if (wait_count == 4'd0) begin
          rd_load   = 1'b1;
          state_nxt = DONE;
        end else begin
          wait_nxt = wait_count - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_count <= 4'd0;
      addr_hold  <= 16'h0000;
      read_data  <= 8'h00;
      open_bus   <= 8'h00;
    end else begin
      state      <= state_nxt;
      wait_count <= wait_nxt;
      addr_hold  <= hold_nxt;
      if (rd_load) begin
        read_data <= dec_byte;
        open_bus  <= dec_byte;
      end else if (wr_en) begin
        // Every captured write byte lands on the open bus, even when the target ignores it.
        open_bus <= data;
      end
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clock0) begin
    if (wr_en && reset && (bus.address < 16'h2000)) begin
      mem[bus.address[RAM_ADDR_BITS-1:0]] <= data;
    end
  end

  assign bus.ready = (state != WAIT);
  assign data      = (reset && bus.readNotWrite) ? read_data : 8'hzz;

`ifdef BUS_RESPONDER_OPCODE_COUNT_EN
  logic [15:0] opcode_count;

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      opcode_count <= 16'h0000;
    end else if (rd_load && bus.sync) begin
      opcode_count <= opcode_count + 16'd1;
    end
  end

  assign bus.opcodeCount = opcode_count;
`else
  logic unused_sync;
  assign unused_sync     = bus.sync;
  assign bus.opcodeCount = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_responder_6502.sv
`timescale 1ns/1ps
module tb_bus_responder_6502;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

`ifdef BUS_RESPONDER_OPCODE_COUNT_EN
  localparam logic [15:0] OPC_HALF = 16'd2;
  localparam logic [15:0] OPC_FULL = 16'd4;
`else
  localparam logic [15:0] OPC_HALF = 16'd0;
  localparam logic [15:0] OPC_FULL = 16'd0;
`endif

  // Three responders with 0, 3 and 5 wait states, each with its own bus.
  logic [15:0] a0, a3, a5;
  logic        rnw0, rnw3, rnw5;
  logic        sy0, sy3, sy5;
  logic        oe0, oe3, oe5;
  logic [7:0]  wd0, wd3, wd5;
  wire  [7:0]  d0, d3, d5;

  assign d0 = oe0 ? wd0 : 8'hzz;
  assign d3 = oe3 ? wd3 : 8'hzz;
  assign d5 = oe5 ? wd5 : 8'hzz;

  bus_responder_6502_if bif0 ();
  bus_responder_6502_if bif3 ();
  bus_responder_6502_if bif5 ();

  assign bif0.address = a0;  assign bif0.readNotWrite = rnw0;  assign bif0.sync = sy0;
  assign bif3.address = a3;  assign bif3.readNotWrite = rnw3;  assign bif3.sync = sy3;
  assign bif5.address = a5;  assign bif5.readNotWrite = rnw5;  assign bif5.sync = sy5;

  bus_responder_6502 #(.WAIT_STATES(0)) u_dut0 (.clock0(clk), .reset(reset), .bus(bif0.slave), .data(d0));
  bus_responder_6502 #(.WAIT_STATES(3)) u_dut3 (.clock0(clk), .reset(reset), .bus(bif3.slave), .data(d3));
  bus_responder_6502 #(.WAIT_STATES(5)) u_dut5 (.clock0(clk), .reset(reset), .bus(bif5.slave), .data(d5));

  // Parking: harmless write to the vector region keeps a responder in IDLE.
  task automatic park_all();
    a0 = 16'hFFFA; rnw0 = 1'b0; sy0 = 1'b0; oe0 = 1'b1; wd0 = 8'h00;
    a3 = 16'hFFFA; rnw3 = 1'b0; sy3 = 1'b0; oe3 = 1'b1; wd3 = 8'h00;
    a5 = 16'hFFFA; rnw5 = 1'b0; sy5 = 1'b0; oe5 = 1'b1; wd5 = 8'h00;
  endtask

  // One bus cycle on the zero-wait responder; returns at the following falling edge.
  task automatic step0(input logic [15:0] ad, input logic rw, input logic [7:0] wdat, input logic s);
    a0 = ad; rnw0 = rw; oe0 = ~rw; wd0 = wdat; sy0 = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rnw0 = 1'b1; oe0 = 1'b1; wd0 = 8'hFF; a0 = 16'hFFFC;
    a5 = 16'h0000; rnw5 = 1'b1; oe5 = 1'b0;
    @(negedge clk);
    tests++; if (bif0.ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", bif0.ready); end
    tests++; if (d0 !== 8'hFF) begin fails++; $display("FAIL rst_data_hiz: got %h want ff (tb only driver)", d0); end
    tests++; if (bif0.opcodeCount !== 16'h0000) begin fails++; $display("FAIL rst_opc: got %h want 0000", bif0.opcodeCount); end
    tests++; if (bif5.ready !== 1'b1) begin fails++; $display("FAIL rst_ready_ws5: got %b want 1", bif5.ready); end
    park_all();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    step0(16'hFFFC, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL vec_fffc: got %h want 00", d0); end
    tests++; if (bif0.ready !== 1'b1) begin fails++; $display("FAIL vec_ready0: got %b want 1", bif0.ready); end
    step0(16'hFFFD, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h80) begin fails++; $display("FAIL vec_fffd: got %h want 80", d0); end
    tests++; if (bif0.ready !== 1'b1) begin fails++; $display("FAIL vec_ready1: got %b want 1", bif0.ready); end
    step0(16'hFFFF, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h80) begin fails++; $display("FAIL vec_ffff: got %h want 80", d0); end
    step0(16'hFFFA, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL vec_fffa: got %h want 00", d0); end
  endtask

  task automatic test_mirror();
    step0(16'h0012, 1'b0, 8'h5A, 1'b0);
    step0(16'h0812, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL mirror_0812: got %h want 5a", d0); end
    step0(16'h1812, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL mirror_1812: got %h want 5a", d0); end
    step0(16'h2012, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL openbus_2012: got %h want 5a", d0); end
    // Top of the RAM window aliases the top of the 2 KiB array.
    step0(16'h1FFF, 1'b0, 8'h77, 1'b0);
    step0(16'h07FF, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h77) begin fails++; $display("FAIL mirror_07ff: got %h want 77", d0); end
    // 0x2000 must not write into RAM location 0.
    step0(16'h0000, 1'b0, 8'h44, 1'b0);
    step0(16'h2000, 1'b0, 8'h33, 1'b0);
    step0(16'h0800, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h44) begin fails++; $display("FAIL ram_2000_not_ram: got %h want 44", d0); end
    step0(16'h3000, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h44) begin fails++; $display("FAIL openbus_after_read: got %h want 44", d0); end
  endtask

  task automatic test_write_protect();
    step0(16'hFFFC, 1'b0, 8'h11, 1'b0);
    step0(16'h4000, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h11) begin fails++; $display("FAIL wp_openbus: got %h want 11", d0); end
    step0(16'hFFFC, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL wp_vector: got %h want 00", d0); end
    step0(16'h4000, 1'b1, 8'h00, 1'b0);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL wp_openbus_after_vec: got %h want 00", d0); end
    park_all();
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int  lows;
    bit  done;
    a3 = 16'h0012; rnw3 = 1'b0; oe3 = 1'b1; wd3 = 8'h5A;
    @(negedge clk);
    a3 = 16'h0012; rnw3 = 1'b1; oe3 = 1'b0;
    tests++; if (bif3.ready !== 1'b1) begin fails++; $display("FAIL ws3_ready_before: got %b want 1", bif3.ready); end
    lows = 0; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (bif3.ready === 1'b0) begin lows++; a3 = 16'hFFFD; end
      else done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL ws3_timeout: ready still %b want 1", bif3.ready); end
    tests++; if (lows != 3) begin fails++; $display("FAIL ws3_low_cycles: got %0d want 3", lows); end
    tests++; if (d3 !== 8'h5A) begin fails++; $display("FAIL ws3_data: got %h want 5a", d3); end
    park_all();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int  lows;
    bit  done;
    a5 = 16'h0012; rnw5 = 1'b1; oe5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (bif5.ready !== 1'b0) begin fails++; $display("FAIL ws5_stalled: got %b want 0", bif5.ready); end
    reset = 1'b0; oe5 = 1'b1; wd5 = 8'hFF;
    #1;
    tests++; if (bif5.ready !== 1'b1) begin fails++; $display("FAIL ws5_abort_ready: got %b want 1", bif5.ready); end
    tests++; if (d5 !== 8'hFF) begin fails++; $display("FAIL ws5_abort_hiz: got %h want ff (tb only driver)", d5); end
    @(negedge clk);
    park_all();
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bif5.ready !== 1'b1) begin fails++; $display("FAIL ws5_idle_after: got %b want 1", bif5.ready); end
    // A fresh read must now take the full five stall cycles, proving IDLE.
    a5 = 16'hFFFD; rnw5 = 1'b1; oe5 = 1'b0;
    lows = 0; done = 1'b0;
    for (int i = 0; i < 14 && !done; i++) begin
      @(negedge clk);
      if (bif5.ready === 1'b0) lows++;
      else done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL ws5_timeout: ready still %b want 1", bif5.ready); end
    tests++; if (lows != 5) begin fails++; $display("FAIL ws5_low_cycles: got %0d want 5", lows); end
    tests++; if (d5 !== 8'h80) begin fails++; $display("FAIL ws5_data: got %h want 80", d5); end
    park_all();
    @(negedge clk);
  endtask

  task automatic test_opcode_count();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bif0.opcodeCount !== 16'h0000) begin fails++; $display("FAIL opc_start: got %h want 0000", bif0.opcodeCount); end
    step0(16'hFFFC, 1'b1, 8'h00, 1'b1);
    step0(16'hFFFD, 1'b1, 8'h00, 1'b0);
    step0(16'h0012, 1'b1, 8'h00, 1'b1);
    tests++; if (bif0.opcodeCount !== OPC_HALF) begin fails++; $display("FAIL opc_half: got %h want %h", bif0.opcodeCount, OPC_HALF); end
    step0(16'h0013, 1'b1, 8'h00, 1'b0);
    step0(16'h4000, 1'b1, 8'h00, 1'b1);
    step0(16'h0800, 1'b1, 8'h00, 1'b1);
    park_all();
    @(negedge clk);
    tests++; if (bif0.opcodeCount !== OPC_FULL) begin fails++; $display("FAIL opc_total: got %h want %h", bif0.opcodeCount, OPC_FULL); end
  endtask

  initial begin
    park_all();
    test_reset();
    test_vectors();
    test_mirror();
    test_write_protect();
    test_wait_states();
    test_reset_mid_wait();
    test_opcode_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
